// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl
// Run/pause/lap/clear controller for an external 16-bit counter. Three
// push-buttons are edge-detected. A prescaler generates the count-enable
// pulses while running. The display can be frozen on a lap value.
module counter_run_ctrl #(
    parameter int          TICK_DIV  = 50000,
    parameter logic [15:0] MAX_COUNT = 16'hFFFF,
    parameter int          WRAP      = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear_req,
    input  logic [15:0] count,
    output logic        cnt_en,
    output logic        cnt_clr_n,
    output logic [15:0] disp,
    output logic        running,
    output logic        lap_active,
    output logic        at_max
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

    state_t      state;
    state_t      state_next;
    logic        start_prev;
    logic        lap_prev;
    logic        clear_prev;
    logic        start_edge;
    logic        lap_edge;
    logic        clear_edge;
    logic        start_evt;
    logic        lap_evt;
    logic [31:0] prescaler;
    logic        tick;
    logic        terminal;
    logic        clr_pulse;
    logic        lap_frozen;
    logic [15:0] lap_reg;

    // Button edge detection. A clear edge masks start and lap edges in the same cycle.
    // A start edge masks a lap edge in the same cycle.
    assign start_edge = start_stop & ~start_prev;
    assign lap_edge   = lap & ~lap_prev;
    assign clear_edge = clear_req & ~clear_prev;
    assign start_evt  = start_edge & ~clear_edge;
    assign lap_evt    = lap_edge & ~start_edge & ~clear_edge;

    // A tick is the last prescaler cycle of a period while running.
    // With WRAP=0, a tick at the terminal count ends the run instead of pulsing.
    assign at_max   = (count == MAX_COUNT);
    assign tick     = (state == RUN) && (prescaler == TICK_LAST);
    assign terminal = (WRAP == 0) && tick && at_max;

    // Previous-value registers start high, so a button held through reset has to be released before it counts as a press
    always_ff @(posedge clk) begin
        if (!resetn) begin
            start_prev <= 1'b1;
            lap_prev   <= 1'b1;
            clear_prev <= 1'b1;
        end else begin
            start_prev <= start_stop;
            lap_prev   <= lap;
            clear_prev <= clear_req;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear wins from any state, and DONE only leaves on clear
    always_comb begin
        state_next = state;
        if (clear_edge) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_evt) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (terminal) begin
                        state_next = DONE;
                    end else if (start_evt) begin
                        state_next = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start_evt) begin
                        state_next = RUN;
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Outputs are gated by resetn, so nothing pulses or reports running during reset
    always_comb begin
        running = 1'b0;
        cnt_en  = 1'b0;
        if (resetn) begin
            running = (state == RUN);
            cnt_en  = tick && !terminal;
        end
    end

    // Prescaler counts in RUN and holds in PAUSE, so a resume continues mid-period.
    // It is zeroed everywhere else.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prescaler <= '0;
        end else if (clear_edge) begin
            prescaler <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (prescaler == TICK_LAST) begin
                        prescaler <= '0;
                    end else begin
                        prescaler <= prescaler + 32'd1;
                    end
                end
                PAUSE: begin
                    prescaler <= prescaler;
                end
                default: begin
                    prescaler <= '0;
                end
            endcase
        end
    end

    // One-cycle clear pulse to the external counter in the cycle after a clear edge
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clr_pulse <= 1'b0;
        end else begin
            clr_pulse <= clear_edge;
        end
    end

    assign cnt_clr_n = resetn & ~clr_pulse;

    // Lap freeze: a press captures the count only while running, and a second press releases it in any state
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lap_frozen <= 1'b0;
            lap_reg    <= '0;
        end else if (clear_edge) begin
            lap_frozen <= 1'b0;
            lap_reg    <= '0;
        end else if (lap_evt) begin
            if (lap_frozen) begin
                lap_frozen <= 1'b0;
            end else if (state == RUN) begin
                lap_frozen <= 1'b1;
                lap_reg    <= count;
            end
        end
    end

    assign lap_active = lap_frozen & resetn;
    assign disp       = lap_active ? lap_reg : count;

endmodule
